mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_LIMIT, default 64, number of implemented memory words; addresses >= ADDR_LIMIT are out of range.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  instruction-fetch request, held until if_ack.
REQ-005 if_addr  input  16  fetch word address.
REQ-006 if_ack  output  1  one-cycle fetch completion strobe.
REQ-007 if_rdata  output  16  fetched word, valid while if_ack=1.
REQ-008 d_req  input  1  data-port request, held until d_ack.
REQ-009 d_we  input  1  1=store, 0=load.
REQ-010 d_addr  input  16  data word address.
REQ-011 d_wdata  input  16  store data.
REQ-012 d_ack  output  1  one-cycle data completion strobe.
REQ-013 d_rdata  output  16  load data, valid while d_ack=1.
REQ-014 err  output  1  out-of-range flag, valid with either ack.
REQ-015 mem_address  output  16  to memory address.
REQ-016 mem_wrdata  output  16  to memory write data.
REQ-017 mem_read  output  1  to memory read enable.
REQ-018 mem_write  output  1  to memory write enable (memory writes on rising clk).
REQ-019 mem_dataout  input  16  combinational read data from memory.

Function
REQ-020 States: IDLE, ACCESS, RESP; one-hot or encoded, implementer's choice.
REQ-021 IDLE: if any req=1, latch winner id, address, we, wdata into registers; next state ACCESS; else stay IDLE.
REQ-022 ACCESS (exactly one cycle): mem_address=latched address; mem_read=1 for fetch or load; mem_write=1 for store; capture mem_dataout into response register at cycle end; next state RESP.
REQ-023 RESP (exactly one cycle): winner's ack=1, its rdata=captured word (16'h0000 for stores); next state IDLE; requests ignored in RESP.
REQ-024 Latency: req seen in IDLE at cycle N -> ACCESS N+1 -> ack N+2; peak one access per 3 cycles.
REQ-025 mem_read and mem_write never both 1; both 0 outside ACCESS; mem_address/mem_wrdata hold last value outside ACCESS.
REQ-026 Out of range (addr >= ADDR_LIMIT): ACCESS drives mem_read=mem_write=0, response word 16'h0000, err=1 with ack; else err=0.
REQ-027 Non-winning request stays pending, served on next IDLE evaluation; no request dropped.
REQ-028 Changing addr/data while req held after IDLE sampling has no effect on the in-flight access.
REQ-029 if_ack and d_ack never asserted in the same cycle.
REQ-030 Requester deasserting req before ack: access still completes and ack still pulses.

Reset
REQ-031 rst_n=0 forces immediately, without clk: state IDLE, if_ack=d_ack=err=0, mem_read=mem_write=0, if_rdata=d_rdata=mem_address=mem_wrdata=16'h0000, priority pointer to data port.
REQ-032 Reset during ACCESS aborts the access; mem_write drops asynchronously; no ack issued after release.
REQ-033 First IDLE evaluation occurs on first rising clk after rst_n deasserts.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests the port not granted last wins; pointer updates on every grant.
REQ-035 Macro undefined: fixed priority, data port always wins simultaneous requests; no pointer register.

Verification
REQ-036 Fetch only: mem[5]=16'h1400, if_req=1, if_addr=5 -> mem_read=1 with mem_address=5 at N+1, if_ack=1, if_rdata=16'h1400, err=0 at N+2.
REQ-037 Store then load: d_we=1, d_addr=20, d_wdata=16'hBEEF -> mem_write=1 one cycle, d_ack; then load d_addr=20 -> d_rdata=16'hBEEF.
REQ-038 Simultaneous if_req (addr 0) and d_req (addr 21): without macro, d_ack first then if_ack 3 cycles later; with macro, two back-to-back contests alternate winners.
REQ-039 Out of range: d_we=1, d_addr=64 -> mem_write stays 0, d_ack=1, err=1, memory unchanged.
REQ-040 Reset mid-access: rst_n=0 during ACCESS of store to 22 -> mem_write falls same cycle, no d_ack, mem[22] unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals of mem_arbiter.
// slave is the arbiter's view; master is the requesters plus the memory.
interface mem_arbiter_if;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_ack;
   logic [15:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic [15:0] d_rdata;
   logic        err;
   logic [15:0] mem_address;
   logic [15:0] mem_wrdata;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_dataout;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dataout,
      output if_ack, if_rdata, d_ack, d_rdata, err,
             mem_address, mem_wrdata, mem_read, mem_write
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dataout,
      input  if_ack, if_rdata, d_ack, d_rdata, err,
             mem_address, mem_wrdata, mem_read, mem_write
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) single-memory arbiter: IDLE -> ACCESS -> RESP, all outputs registered.
// Define ARB_ROUND_ROBIN_EN for alternating priority; default build gives the data port fixed priority.
module mem_arbiter #(
   parameter int unsigned ADDR_LIMIT = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

   state_t      r_state;
   logic        r_win_d;
   logic        r_we;
   logic        r_oor;
   logic        r_if_ack;
   logic        r_d_ack;
   logic        r_err;
   logic [15:0] r_if_rdata;
   logic [15:0] r_d_rdata;
   logic [15:0] r_mem_address;
   logic [15:0] r_mem_wrdata;
   logic        r_mem_read;
   logic        r_mem_write;

   logic        w_grant_d;
   logic        w_store;
   logic [15:0] w_sel_addr;
   logic        w_sel_oor;
   logic [15:0] w_resp;

`ifdef ARB_ROUND_ROBIN_EN
   // Set when the data port should win the next simultaneous contest.
   logic r_prio_d;
   assign w_grant_d = bus.d_req & (~bus.if_req | r_prio_d);
`else
   assign w_grant_d = bus.d_req;
`endif

   assign w_store    = w_grant_d & bus.d_we;
   assign w_sel_addr = w_grant_d ? bus.d_addr : bus.if_addr;
   assign w_sel_oor  = (32'(w_sel_addr) >= ADDR_LIMIT);
   assign w_resp     = (r_oor || r_we) ? 16'h0000 : bus.mem_dataout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_win_d       <= 1'b0;
         r_we          <= 1'b0;
         r_oor         <= 1'b0;
         r_if_ack      <= 1'b0;
         r_d_ack       <= 1'b0;
         r_err         <= 1'b0;
         r_if_rdata    <= 16'h0000;
         r_d_rdata     <= 16'h0000;
         r_mem_address <= 16'h0000;
         r_mem_wrdata  <= 16'h0000;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         r_prio_d      <= 1'b1;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.if_req || bus.d_req) begin
                  r_win_d       <= w_grant_d;
                  r_we          <= w_store;
                  r_oor         <= w_sel_oor;
                  r_mem_address <= w_sel_addr;
                  if (w_store) begin
                     r_mem_wrdata <= bus.d_wdata;
                  end
                  // Out-of-range accesses never touch the memory.
                  r_mem_read    <= ~w_sel_oor & ~w_store;
                  r_mem_write   <= ~w_sel_oor & w_store;
`ifdef ARB_ROUND_ROBIN_EN
                  r_prio_d      <= ~w_grant_d;
`endif
                  r_state       <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               r_mem_read  <= 1'b0;
               r_mem_write <= 1'b0;
               r_err       <= r_oor;
               if (r_win_d) begin
                  r_d_ack   <= 1'b1;
                  r_d_rdata <= w_resp;
               end else begin
                  r_if_ack   <= 1'b1;
                  r_if_rdata <= w_resp;
               end
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               r_if_ack <= 1'b0;
               r_d_ack  <= 1'b0;
               r_err    <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.if_ack      = r_if_ack;
   assign bus.if_rdata    = r_if_rdata;
   assign bus.d_ack       = r_d_ack;
   assign bus.d_rdata     = r_d_rdata;
   assign bus.err         = r_err;
   assign bus.mem_address = r_mem_address;
   assign bus.mem_wrdata  = r_mem_wrdata;
   assign bus.mem_read    = r_mem_read;
   assign bus.mem_write   = r_mem_write;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus random traffic against a
// word-array reference memory and a "port not granted last" / "data wins" priority rule.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int LIM = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();
   mem_arbiter #(.ADDR_LIMIT(LIM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // Physical memory seen by the arbiter (aliases addresses to 6 bits).
   logic [15:0] mem     [0:LIM-1];
   logic [15:0] ref_mem [0:LIM-1];
   logic        load_mem = 1'b0;
   int          total = 0;
   int          bad = 0;
   bit          last_d = 1'b0;

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < LIM; i++) mem[i] <= ref_mem[i];
      end else if (bus.mem_write) begin
         mem[bus.mem_address[5:0]] <= bus.mem_wrdata;
      end
   end
   assign bus.mem_dataout = mem[bus.mem_address[5:0]];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.if_req  = 1'b0;
      bus.if_addr = 16'h0000;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 16'h0000;
      bus.d_wdata = 16'h0000;
   endtask

   // Reference behaviour of one access; updates the reference memory for stores.
   task automatic model(input bit is_d, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] word, output logic e);
      bit oor;
      bit store;
      oor   = (32'(addr) >= LIM);
      store = is_d && we;
      e     = oor;
      word  = (oor || store) ? 16'h0000 : ref_mem[addr[5:0]];
      if (store && !oor) ref_mem[addr[5:0]] = wdata;
   endtask

   task automatic check_access(input string tag, input bit is_d, input bit we, input logic [15:0] addr,
                               input logic [15:0] wdata);
      bit oor;
      bit store;
      oor   = (32'(addr) >= LIM);
      store = is_d && we;
      check({tag, "_addr"}, bus.mem_address, addr);
      check({tag, "_rd"}, 16'(bus.mem_read), 16'(!oor && !store));
      check({tag, "_wr"}, 16'(bus.mem_write), 16'(!oor && store));
      if (store && !oor) check({tag, "_wdata"}, bus.mem_wrdata, wdata);
   endtask

   task automatic check_resp(input string tag, input bit is_d, input logic [15:0] word, input logic e);
      check({tag, "_d_ack"}, 16'(bus.d_ack), 16'(is_d));
      check({tag, "_if_ack"}, 16'(bus.if_ack), 16'(!is_d));
      if (is_d) check({tag, "_d_rdata"}, bus.d_rdata, word);
      else      check({tag, "_if_rdata"}, bus.if_rdata, word);
      check({tag, "_err"}, 16'(bus.err), 16'(e));
      check({tag, "_rw_off"}, 16'({bus.mem_read, bus.mem_write}), 16'h0000);
   endtask

   task automatic do_single(input bit is_d, input bit we, input logic [15:0] addr,
                            input logic [15:0] wdata, input bit drop_early);
      logic [15:0] word;
      logic        e;
      if (is_d) begin
         bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = addr;
      end
      tick();
      check_access("single", is_d, we, addr, wdata);
      bus.if_addr = 16'($urandom); bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
      if (drop_early) begin
         bus.if_req = 1'b0; bus.d_req = 1'b0;
      end
      model(is_d, we, addr, wdata, word, e);
      last_d = is_d;
      tick();
      check_resp("single", is_d, word, e);
      $display("txn single port=%s we=%0d addr=%0d word=%h err=%0d drop=%0d",
               is_d ? "D" : "IF", we, addr, word, e, drop_early);
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      tick();
      check("single_idle_acks", 16'({bus.if_ack, bus.d_ack}), 16'h0000);
   endtask

   task automatic do_both(input bit we, input logic [15:0] d_addr, input logic [15:0] wdata,
                          input logic [15:0] i_addr);
      bit          win_d;
      logic [15:0] w_word, l_word;
      logic        w_err, l_err;
`ifdef ARB_ROUND_ROBIN_EN
      win_d = !last_d;
`else
      win_d = 1'b1;
`endif
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = d_addr; bus.d_wdata = wdata;
      bus.if_req = 1'b1; bus.if_addr = i_addr;
      tick();
      check_access("both_w", win_d, we, win_d ? d_addr : i_addr, wdata);
      model(win_d, we, win_d ? d_addr : i_addr, wdata, w_word, w_err);
      tick();
      check_resp("both_w", win_d, w_word, w_err);
      if (win_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
      tick();
      check("both_gap1_acks", 16'({bus.if_ack, bus.d_ack}), 16'h0000);
      tick();
      check("both_gap2_acks", 16'({bus.if_ack, bus.d_ack}), 16'h0000);
      check_access("both_l", !win_d, we, win_d ? i_addr : d_addr, wdata);
      model(!win_d, we, win_d ? i_addr : d_addr, wdata, l_word, l_err);
      tick();
      check_resp("both_l", !win_d, l_word, l_err);
      $display("txn both first=%s d_we=%0d d_addr=%0d if_addr=%0d first_word=%h second_word=%h",
               win_d ? "D" : "IF", we, d_addr, i_addr, w_word, l_word);
      last_d = !win_d;
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      tick();
   endtask

   initial begin
      drive_idle();
      for (int i = 0; i < LIM; i++) ref_mem[i] = 16'($urandom);
      ref_mem[5]  = 16'h1400;
      ref_mem[22] = 16'h2222;
      load_mem = 1'b1;
      tick();
      load_mem = 1'b0;
      tick();
      check("rst_acks", 16'({bus.if_ack, bus.d_ack, bus.err}), 16'h0000);
      check("rst_rw", 16'({bus.mem_read, bus.mem_write}), 16'h0000);
      check("rst_if_rdata", bus.if_rdata, 16'h0000);
      check("rst_d_rdata", bus.d_rdata, 16'h0000);
      check("rst_mem_address", bus.mem_address, 16'h0000);
      check("rst_mem_wrdata", bus.mem_wrdata, 16'h0000);
      rst_n = 1'b1;

      do_single(1'b0, 1'b0, 16'd5, 16'h0000, 1'b0);
      do_single(1'b1, 1'b1, 16'd20, 16'hBEEF, 1'b0);
      do_single(1'b1, 1'b0, 16'd20, 16'h0000, 1'b0);
      do_single(1'b1, 1'b1, 16'd64, 16'hDEAD, 1'b0);
      do_single(1'b0, 1'b0, 16'd63, 16'h0000, 1'b1);
      do_single(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
      do_both(1'b0, 16'd21, 16'h0000, 16'd0);
      do_both(1'b1, 16'd21, 16'h5A5A, 16'd0);

      // Reset in the middle of a store to word 22.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'd22; bus.d_wdata = 16'hCAFE;
      tick();
      check("rstmid_wr_before", 16'(bus.mem_write), 16'h0001);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_wr_async", 16'(bus.mem_write), 16'h0000);
      check("rstmid_addr_async", bus.mem_address, 16'h0000);
      check("rstmid_acks_async", 16'({bus.if_ack, bus.d_ack, bus.err}), 16'h0000);
      bus.d_req = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b1;
      last_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rstmid_no_ack", 16'({bus.if_ack, bus.d_ack}), 16'h0000);
      end
      check("rstmid_mem22", mem[22], ref_mem[22]);
      do_single(1'b1, 1'b0, 16'd22, 16'h0000, 1'b0);

      for (int n = 0; n < 30; n++) begin
         do_single(1'($urandom), 1'($urandom), 16'($urandom_range(0, 79)),
                   16'($urandom), 1'($urandom));
      end
      for (int n = 0; n < 10; n++) begin
         do_both(1'($urandom), 16'($urandom_range(0, 79)), 16'($urandom),
                 16'($urandom_range(0, 79)));
      end

      for (int i = 0; i < LIM; i++) check("final_mem", mem[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
